mmio_bus_ctrl: RTL and testbench
================================

// Module: mmio_bus_ctrl
// PURPOSE
//  Sequences all MMIO accesses between two bus masters (m0 = CPU mem stage, m1 = debug/loader) and
//  N_SLV peripherals (timers, LEDs, UART, ...) sharing one broadcast bus with the work/done handshake.
//  Arbitrates masters round-robin, holds each access until the claiming peripheral returns done,
//  muxes read data back, and raises a bus error on no-claim, multi-claim or timeout.
// PARAMETERS
//  N_SLV      4    number of peripherals on the bus (1..8)
//  TMO_CYC    255  max cycles in ISSUE waiting for done before timeout error (1..255)
// PORTS
//  sys_clk          in   1        clock
//  rst_n            in   1        synchronous, active-low reset
//  m0_req/m1_req    in   1        access request; held stable with we/addr/wdata until ack
//  m0_we/m1_we      in   1        1 = write, 0 = read
//  m0_addr/m1_addr  in   32       byte address
//  m0_wdata/m1_wdata in  32       write data
//  m0_ack/m1_ack    out  1        one-cycle completion pulse
//  m0_err/m1_err    out  1        valid with ack: 1 = bus error
//  m0_rdata/m1_rdata out 32       read data, valid with ack; 0 on write or error
//  mmio_read        out  1        broadcast read strobe
//  mmio_write       out  1        broadcast write strobe
//  mmio_addr        out  32       broadcast address
//  mmio_write_data  out  32       broadcast write data
//  slv_work         in   N_SLV    per-peripheral claim (combinational address decode)
//  slv_done         in   N_SLV    per-peripheral done
//  slv_rdata        in   32*N_SLV per-peripheral read data, slice i = [32*i+31:32*i]
// BEHAVIOUR
//  Reset: state IDLE, all outputs 0, last-grant = m1 (so m0 wins first tie), timeout counter 0.
//  FSM IDLE -> ISSUE -> RESP -> IDLE; reset from any state returns to IDLE, strobes drop same edge.
//  IDLE: no strobes. If any req: grant per round-robin (alternate when both pending, else the
//   single requester); latch we/addr/wdata into bus regs; -> ISSUE. Grant updates last-grant.
//  ISSUE: mmio_read = !we, mmio_write = we, addr/wdata from latched regs (stable whole phase).
//   First ISSUE cycle: popcount(slv_work)==0 -> error (no-claim); >1 -> error (multi-claim);
//   error -> RESP with err=1, strobes drop next cycle, no done wait.
//   Otherwise claimant index k latched; wait for slv_done[k]. Cycle slv_done[k]=1: capture
//   slv_rdata[k] (reads) -> RESP. done from non-claimant ignored.
//   Counter increments each ISSUE cycle; reaching TMO_CYC without done -> RESP with err=1.
//  RESP: strobes 0 (peripheral sees request drop after done); granted master gets ack=1 for
//   exactly this cycle with err/rdata; other master ack=0. -> IDLE. Minimum access = 3 cycles
//   (IDLE grant, ISSUE w/ done, RESP); peripheral with done one cycle after work = 4 cycles.
//  Master dropping req mid-access: access completes on the bus; ack still pulsed (undefined use).
//  rdata/err outputs are 0 whenever ack=0. Back-to-back: a new grant occurs in the IDLE cycle after
//   RESP; a req held through RESP is not re-granted until that IDLE cycle.
//  Counter width 8 bits; cleared on entry to ISSUE; no wrap (TMO_CYC <= 255).
// TESTING
//  m0 read 0xFFFF0288, slave 1 work, done 1 cycle later with rdata 0x1234 -> m0_ack at cycle 4,
//   m0_rdata=0x1234, err=0; mmio_read high exactly 2 cycles.
//  m0 and m1 req same cycle after reset -> m0 granted first, m1 next; repeat with both held ->
//   strict alternation m0,m1,m0,m1.
//  m1 write to 0xFFFF1000, no slave claims -> m1_ack+err=1 at cycle 3, mmio_write high 1 cycle.
//  Slaves 0 and 2 both claim -> err=1, no data captured.
//  Claimed slave never asserts done, TMO_CYC=8 -> err=1 after 8 ISSUE cycles, strobes drop.
//  rst_n low during ISSUE -> next cycle strobes 0, no ack; subsequent access completes normally.

Source files
------------

// File: rtl/mmio_bus_ctrl_if.sv
// Bundled MMIO signals: two master request/response channels plus the shared
// broadcast peripheral bus with per-peripheral claim/done/read-data returns.
interface mmio_bus_ctrl_if #(
  parameter int N_SLV = 4
);
  logic                   m0_req;
  logic                   m0_we;
  logic [31:0]            m0_addr;
  logic [31:0]            m0_wdata;
  logic                   m0_ack;
  logic                   m0_err;
  logic [31:0]            m0_rdata;

  logic                   m1_req;
  logic                   m1_we;
  logic [31:0]            m1_addr;
  logic [31:0]            m1_wdata;
  logic                   m1_ack;
  logic                   m1_err;
  logic [31:0]            m1_rdata;

  logic                   mmio_read;
  logic                   mmio_write;
  logic [31:0]            mmio_addr;
  logic [31:0]            mmio_write_data;
  logic [N_SLV-1:0]       slv_work;
  logic [N_SLV-1:0]       slv_done;
  logic [32*N_SLV-1:0]    slv_rdata;

  // Controller view.
  modport master (
    input  m0_req, m0_we, m0_addr, m0_wdata,
    output m0_ack, m0_err, m0_rdata,
    input  m1_req, m1_we, m1_addr, m1_wdata,
    output m1_ack, m1_err, m1_rdata,
    output mmio_read, mmio_write, mmio_addr, mmio_write_data,
    input  slv_work, slv_done, slv_rdata
  );

  // Environment view: masters and peripherals.
  modport slave (
    output m0_req, m0_we, m0_addr, m0_wdata,
    input  m0_ack, m0_err, m0_rdata,
    output m1_req, m1_we, m1_addr, m1_wdata,
    input  m1_ack, m1_err, m1_rdata,
    input  mmio_read, mmio_write, mmio_addr, mmio_write_data,
    output slv_work, slv_done, slv_rdata
  );
endinterface

// File: rtl/mmio_bus_ctrl.sv
// Round-robin two-master MMIO sequencer with claim checking, done wait and timeout.
// Access takes IDLE grant + ISSUE (>=1 cycle) + RESP ack; masters hold req until ack.
module mmio_bus_ctrl #(
  parameter int N_SLV   = 4,
  parameter int TMO_CYC = 255
) (
  input  logic            sys_clk,
  input  logic            rst_n,
  mmio_bus_ctrl_if.master bus
);
  localparam int IW = (N_SLV > 1) ? $clog2(N_SLV) : 1;

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_RESP} state_t;

  state_t        state_q, state_d;
  logic          last_gnt_q, last_gnt_d;
  logic          gnt_q, gnt_d;
  logic          we_q, we_d;
  logic [31:0]   addr_q, addr_d;
  logic [31:0]   wdata_q, wdata_d;
  logic          rd_q, rd_d;
  logic          wr_q, wr_d;
  logic [7:0]    cnt_q, cnt_d;
  logic [IW-1:0] claim_q, claim_d;
  logic          ack0_q, ack0_d;
  logic          ack1_q, ack1_d;
  logic          err_q, err_d;
  logic [31:0]   rdata_q, rdata_d;

  logic [3:0]    n_claim;
  logic [IW-1:0] enc_idx;
  logic [IW-1:0] cur_idx;
  logic          sel_done;
  logic [31:0]   sel_rdata;
  logic          first;
  logic          grant_m1;
  logic          finish;
  logic          fin_err;

  always_comb begin
    n_claim = '0;
    enc_idx = '0;
    for (int i = 0; i < N_SLV; i++) begin
      if (bus.slv_work[i]) begin
        n_claim = n_claim + 4'd1;
        enc_idx = IW'(i);
      end
    end
  end

  // Counter is zero only in the first ISSUE cycle, where the live decode is used.
  assign first   = (cnt_q == 8'd0);
  assign cur_idx = first ? enc_idx : claim_q;

  always_comb begin
    sel_done  = 1'b0;
    sel_rdata = '0;
    for (int i = 0; i < N_SLV; i++) begin
      if (cur_idx == IW'(i)) begin
        sel_done  = bus.slv_done[i];
        sel_rdata = bus.slv_rdata[32*i +: 32];
      end
    end
  end

  always_comb begin
    state_d    = state_q;
    last_gnt_d = last_gnt_q;
    gnt_d      = gnt_q;
    we_d       = we_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    rd_d       = rd_q;
    wr_d       = wr_q;
    cnt_d      = cnt_q;
    claim_d    = claim_q;
    ack0_d     = 1'b0;
    ack1_d     = 1'b0;
    err_d      = 1'b0;
    rdata_d    = '0;
    grant_m1   = 1'b0;
    finish     = 1'b0;
    fin_err    = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (bus.m0_req || bus.m1_req) begin
          grant_m1   = (bus.m0_req && bus.m1_req) ? !last_gnt_q : bus.m1_req;
          gnt_d      = grant_m1;
          last_gnt_d = grant_m1;
          we_d       = grant_m1 ? bus.m1_we    : bus.m0_we;
          addr_d     = grant_m1 ? bus.m1_addr  : bus.m0_addr;
          wdata_d    = grant_m1 ? bus.m1_wdata : bus.m0_wdata;
          rd_d       = !we_d;
          wr_d       = we_d;
          cnt_d      = 8'd0;
          state_d    = S_ISSUE;
        end
      end
      S_ISSUE: begin
        if (first && (n_claim != 4'd1)) begin
          finish  = 1'b1;
          fin_err = 1'b1;
        end else begin
          claim_d = cur_idx;
          if (sel_done) begin
            finish = 1'b1;
          end else begin
            cnt_d = cnt_q + 8'd1;
            if (cnt_d == 8'(TMO_CYC)) begin
              finish  = 1'b1;
              fin_err = 1'b1;
            end
          end
        end
      end
      S_RESP: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    if (finish) begin
      state_d = S_RESP;
      rd_d    = 1'b0;
      wr_d    = 1'b0;
      ack0_d  = !gnt_q;
      ack1_d  = gnt_q;
      err_d   = fin_err;
      rdata_d = (fin_err || we_q) ? 32'd0 : sel_rdata;
    end
  end

  always_ff @(posedge sys_clk) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      last_gnt_q <= 1'b1;
      gnt_q      <= 1'b0;
      we_q       <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
      rd_q       <= 1'b0;
      wr_q       <= 1'b0;
      cnt_q      <= '0;
      claim_q    <= '0;
      ack0_q     <= 1'b0;
      ack1_q     <= 1'b0;
      err_q      <= 1'b0;
      rdata_q    <= '0;
    end else begin
      state_q    <= state_d;
      last_gnt_q <= last_gnt_d;
      gnt_q      <= gnt_d;
      we_q       <= we_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      rd_q       <= rd_d;
      wr_q       <= wr_d;
      cnt_q      <= cnt_d;
      claim_q    <= claim_d;
      ack0_q     <= ack0_d;
      ack1_q     <= ack1_d;
      err_q      <= err_d;
      rdata_q    <= rdata_d;
    end
  end

  assign bus.mmio_read       = rd_q;
  assign bus.mmio_write      = wr_q;
  assign bus.mmio_addr       = addr_q;
  assign bus.mmio_write_data = wdata_q;
  assign bus.m0_ack          = ack0_q;
  assign bus.m1_ack          = ack1_q;
  assign bus.m0_err          = ack0_q & err_q;
  assign bus.m1_err          = ack1_q & err_q;
  assign bus.m0_rdata        = ack0_q ? rdata_q : 32'd0;
  assign bus.m1_rdata        = ack1_q ? rdata_q : 32'd0;
endmodule

// File: tb/tb_mmio_bus_ctrl.sv
// Randomized and directed bench for mmio_bus_ctrl against a per-access outcome model.
module tb_mmio_bus_ctrl;
  localparam int N   = 4;
  localparam int TMO = 8;

  logic sys_clk = 1'b0;
  logic rst_n   = 1'b0;
  always #5 sys_clk = ~sys_clk;

  mmio_bus_ctrl_if #(.N_SLV(N)) bus();
  mmio_bus_ctrl #(.N_SLV(N), .TMO_CYC(TMO)) dut (
    .sys_clk (sys_clk),
    .rst_n   (rst_n),
    .bus     (bus)
  );

  int vectors     = 0;
  int miscompares = 0;
  int model_last  = 1;

  // Behavioural peripherals: claim mask, done delay in ISSUE cycles, stray done bits.
  logic [N-1:0]    cur_mask  = '0;
  logic [N-1:0]    cur_noise = '0;
  int              cur_dly   = 0;
  logic [32*N-1:0] rdata_vec = '0;
  int              issue_cnt = 0;
  logic            strobe;

  assign strobe        = bus.mmio_read | bus.mmio_write;
  assign bus.slv_rdata = rdata_vec;
  always @(posedge sys_clk) issue_cnt <= strobe ? issue_cnt + 1 : 0;
  always_comb begin
    bus.slv_work = strobe ? cur_mask : '0;
    bus.slv_done = '0;
    if (strobe) bus.slv_done = cur_noise | ((issue_cnt == cur_dly) ? cur_mask : '0);
  end

  task automatic drive_master(input int m, input logic req, input logic we,
                              input logic [31:0] a, input logic [31:0] d);
    if (m == 0) begin
      bus.m0_req = req; bus.m0_we = we; bus.m0_addr = a; bus.m0_wdata = d;
    end else begin
      bus.m1_req = req; bus.m1_we = we; bus.m1_addr = a; bus.m1_wdata = d;
    end
  endtask

  // Expected outcome of one access from the claim/done/timeout rules.
  function automatic void model(input logic we, input logic [N-1:0] mask, input int dly,
                                output int cyc, output logic err, output logic [31:0] rd);
    int k;
    k = 0;
    for (int i = 0; i < N; i++) if (mask[i]) k = i;
    if ($countones(mask) != 1) begin
      cyc = 3; err = 1'b1; rd = 32'd0;
    end else if (dly < TMO) begin
      cyc = 3 + dly; err = 1'b0; rd = we ? 32'd0 : rdata_vec[32*k +: 32];
    end else begin
      cyc = 2 + TMO; err = 1'b1; rd = 32'd0;
    end
  endfunction

  // Runs one access from master m; returns observations only. Entered and left at posedge+1.
  task automatic run_access(input int m, input logic we, input logic [31:0] a, input logic [31:0] d,
                            input logic [N-1:0] mask, input int dly,
                            output int cyc, output logic err, output logic [31:0] rd,
                            output int strb, output bit bus_ok, output bit quiet_ok);
    bit seen;
    logic my_ack, ot_ack;
    cur_mask  = mask;
    cur_dly   = dly;
    cur_noise = N'($urandom) & ~mask;
    drive_master(m, 1'b1, we, a, d);
    cyc = 0; strb = 0; err = 1'bx; rd = 'x; seen = 0; bus_ok = 1; quiet_ok = 1;
    while (!seen && cyc < 40) begin
      @(negedge sys_clk);
      cyc++;
      my_ack = (m == 0) ? bus.m0_ack : bus.m1_ack;
      ot_ack = (m == 0) ? bus.m1_ack : bus.m0_ack;
      if (strobe) begin
        strb++;
        if (bus.mmio_read !== !we || bus.mmio_write !== we ||
            bus.mmio_addr !== a || bus.mmio_write_data !== d) bus_ok = 0;
      end
      if (ot_ack !== 1'b0) quiet_ok = 0;
      if (!bus.m0_ack && (bus.m0_err !== 1'b0 || bus.m0_rdata !== 32'd0)) quiet_ok = 0;
      if (!bus.m1_ack && (bus.m1_err !== 1'b0 || bus.m1_rdata !== 32'd0)) quiet_ok = 0;
      if (my_ack === 1'b1) begin
        seen = 1;
        err  = (m == 0) ? bus.m0_err : bus.m1_err;
        rd   = (m == 0) ? bus.m0_rdata : bus.m1_rdata;
      end
    end
    if (!seen) cyc = -1;
    @(posedge sys_clk); #1;
    drive_master(m, 1'b0, 1'b0, 32'd0, 32'd0);
    cur_noise = '0;
    model_last = m;
  endtask

  task automatic test_reset();
    drive_master(0, 1'b0, 1'b0, 32'd0, 32'd0);
    drive_master(1, 1'b0, 1'b0, 32'd0, 32'd0);
    rst_n = 1'b0;
    repeat (3) @(posedge sys_clk);
    @(negedge sys_clk);
    vectors++;
    if ({bus.mmio_read, bus.mmio_write} !== 2'b00) begin
      miscompares++; $display("FAIL reset_strobes got %b expected 00", {bus.mmio_read, bus.mmio_write});
    end
    vectors++;
    if ({bus.m0_ack, bus.m1_ack, bus.m0_err, bus.m1_err} !== 4'b0) begin
      miscompares++; $display("FAIL reset_ack_err got %b expected 0000",
                              {bus.m0_ack, bus.m1_ack, bus.m0_err, bus.m1_err});
    end
    vectors++;
    if ({bus.mmio_addr, bus.mmio_write_data, bus.m0_rdata, bus.m1_rdata} !== 128'd0) begin
      miscompares++; $display("FAIL reset_data got addr=%h wd=%h r0=%h r1=%h expected all 0",
                              bus.mmio_addr, bus.mmio_write_data, bus.m0_rdata, bus.m1_rdata);
    end
    @(posedge sys_clk); #1;
    rst_n = 1'b1;
    model_last = 1;
    repeat (3) @(negedge sys_clk);
    vectors++;
    if (strobe !== 1'b0) begin
      miscompares++; $display("FAIL idle_no_strobe got %b expected 0", strobe);
    end
    @(posedge sys_clk); #1;
  endtask

  task automatic test_directed();
    int m[4]; logic we[4]; logic [31:0] ad[4]; logic [N-1:0] mk[4]; int dl[4];
    int cyc, ecyc, strb; logic err, eerr; logic [31:0] rd, erd; bit bok, qok;
    // read w/ late done, unclaimed write, double claim, never-done timeout
    m  = '{0, 1, 0, 1};
    we = '{1'b0, 1'b1, 1'b0, 1'b1};
    ad = '{32'hFFFF0288, 32'hFFFF1000, 32'hFFFF0300, 32'hFFFF0400};
    mk = '{4'b0010, 4'b0000, 4'b0101, 4'b1000};
    dl = '{1, 0, 0, 255};
    for (int t = 0; t < 4; t++) begin
      for (int k = 0; k < N; k++) rdata_vec[32*k +: 32] = $urandom;
      rdata_vec[63:32] = 32'h0000_1234;
      model(we[t], mk[t], dl[t], ecyc, eerr, erd);
      run_access(m[t], we[t], ad[t], 32'hA5A5_0000 + t, mk[t], dl[t], cyc, err, rd, strb, bok, qok);
      vectors++;
      if (cyc !== ecyc) begin miscompares++; $display("FAIL dir%0d ack_cycle got %0d expected %0d", t, cyc, ecyc); end
      vectors++;
      if (err !== eerr) begin miscompares++; $display("FAIL dir%0d err got %b expected %b", t, err, eerr); end
      vectors++;
      if (rd !== erd) begin miscompares++; $display("FAIL dir%0d rdata got %h expected %h", t, rd, erd); end
      vectors++;
      if (strb !== ecyc - 2) begin miscompares++; $display("FAIL dir%0d strobe_cycles got %0d expected %0d", t, strb, ecyc - 2); end
      vectors++;
      if (!bok || !qok) begin miscompares++; $display("FAIL dir%0d bus_integrity got bus=%0d quiet=%0d expected 1 1", t, bok, qok); end
    end
  endtask

  task automatic test_arbitration();
    int cyc, n, exp_w, w;
    cur_mask = 4'b0010; cur_dly = 0; cur_noise = '0;
    rdata_vec[63:32] = 32'hCAFE_0001;
    drive_master(0, 1'b1, 1'b0, 32'hFFFF0010, 32'd0);
    drive_master(1, 1'b1, 1'b0, 32'hFFFF0020, 32'd0);
    cyc = 0; n = 0;
    while (n < 4 && cyc < 30) begin
      @(negedge sys_clk);
      cyc++;
      if (bus.m0_ack || bus.m1_ack) begin
        w = bus.m1_ack ? 1 : 0;
        exp_w = 1 - model_last;
        model_last = exp_w;
        vectors++;
        if ({bus.m1_ack, bus.m0_ack} !== (exp_w ? 2'b10 : 2'b01)) begin
          miscompares++; $display("FAIL arb_winner%0d got m0=%b m1=%b expected m%0d", n, bus.m0_ack, bus.m1_ack, exp_w);
        end
        vectors++;
        if (cyc !== 3 * (n + 1)) begin
          miscompares++; $display("FAIL arb_cycle%0d got %0d expected %0d", n, cyc, 3 * (n + 1));
        end
        vectors++;
        if ((w ? bus.m1_rdata : bus.m0_rdata) !== 32'hCAFE_0001) begin
          miscompares++; $display("FAIL arb_rdata%0d got %h expected cafe0001", n, w ? bus.m1_rdata : bus.m0_rdata);
        end
        n++;
      end
    end
    vectors++;
    if (n !== 4) begin miscompares++; $display("FAIL arb_count got %0d expected 4", n); end
    @(posedge sys_clk); #1;
    drive_master(0, 1'b0, 1'b0, 32'd0, 32'd0);
    drive_master(1, 1'b0, 1'b0, 32'd0, 32'd0);
  endtask

  task automatic test_reset_mid_issue();
    int cyc, ecyc, strb; logic err, eerr; logic [31:0] rd, erd; bit bok, qok;
    cur_mask = 4'b0100; cur_dly = 255; cur_noise = '0;
    drive_master(1, 1'b1, 1'b1, 32'hFFFF0040, 32'h0000DEAD);
    repeat (3) @(negedge sys_clk);
    vectors++;
    if (bus.mmio_write !== 1'b1) begin miscompares++; $display("FAIL rst_mid_pre got write=%b expected 1", bus.mmio_write); end
    @(posedge sys_clk); #1;
    rst_n = 1'b0;
    @(posedge sys_clk);
    @(negedge sys_clk);
    vectors++;
    if ({strobe, bus.m0_ack, bus.m1_ack} !== 3'b000) begin
      miscompares++; $display("FAIL rst_mid_drop got strobe=%b ack0=%b ack1=%b expected 0 0 0", strobe, bus.m0_ack, bus.m1_ack);
    end
    @(posedge sys_clk); #1;
    drive_master(1, 1'b0, 1'b0, 32'd0, 32'd0);
    rst_n = 1'b1;
    model_last = 1;
    rdata_vec[95:64] = 32'h0BAD_F00D;
    model(1'b0, 4'b0100, 2, ecyc, eerr, erd);
    run_access(0, 1'b0, 32'hFFFF0044, 32'd0, 4'b0100, 2, cyc, err, rd, strb, bok, qok);
    vectors++;
    if (cyc !== ecyc || err !== eerr || rd !== erd) begin
      miscompares++; $display("FAIL rst_mid_after got cyc=%0d err=%b rd=%h expected cyc=%0d err=%b rd=%h", cyc, err, rd, ecyc, eerr, erd);
    end
  endtask

  task automatic test_random_back_to_back();
    int m, dly, r, i, j, cyc, ecyc, strb; logic we, err, eerr; logic [31:0] a, d, rd, erd;
    logic [N-1:0] mask, one; bit bok, qok;
    one = 1;
    for (int t = 0; t < 40; t++) begin
      m = $urandom_range(0, 1); we = 1'($urandom); a = $urandom; d = $urandom;
      r = $urandom_range(0, 9);
      if (r < 6) mask = one << $urandom_range(0, N - 1);
      else if (r < 8) mask = '0;
      else begin
        i = $urandom_range(0, N - 1);
        j = (i + 1 + $urandom_range(0, N - 2)) % N;
        mask = (one << i) | (one << j);
      end
      dly = $urandom_range(0, 10);
      for (int k = 0; k < N; k++) rdata_vec[32*k +: 32] = $urandom;
      model(we, mask, dly, ecyc, eerr, erd);
      run_access(m, we, a, d, mask, dly, cyc, err, rd, strb, bok, qok);
      vectors++;
      if (cyc !== ecyc || err !== eerr || rd !== erd) begin
        miscompares++; $display("FAIL rnd%0d outcome got cyc=%0d err=%b rd=%h expected cyc=%0d err=%b rd=%h", t, cyc, err, rd, ecyc, eerr, erd);
      end
      vectors++;
      if (strb !== ecyc - 2 || !bok || !qok) begin
        miscompares++; $display("FAIL rnd%0d bus got strobes=%0d bus=%0d quiet=%0d expected %0d 1 1", t, strb, bok, qok, ecyc - 2);
      end
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_arbitration();
    test_reset_mid_issue();
    test_random_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
